// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: default geometry,
// the buffered line record and the count clamp.
package fetch_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_INSTR = 5;
  localparam int CNT_W     = $clog2(NUM_INSTR);

  typedef struct packed {
    logic [NUM_INSTR*XLEN-1:0] data;
    logic [CNT_W:0]            count;
  } line_t;

  // Memory may report more valid slots than a line physically holds.
  function automatic int unsigned clamp_count(input int unsigned count,
                                              input int unsigned limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/instr_slot_mux.sv
// NUM_INSTR:1 selector picking one XLEN-bit instruction out of a memory line.
// Out-of-range selects fall back to slot 0.
module instr_slot_mux
  import fetch_pkg::*;
#(
  parameter int XLEN      = fetch_pkg::XLEN,
  parameter int NUM_INSTR = fetch_pkg::NUM_INSTR,
  parameter int SEL_W     = fetch_pkg::CNT_W
) (
  input  logic [NUM_INSTR*XLEN-1:0] data,
  input  logic [SEL_W-1:0]          sel,
  output logic [XLEN-1:0]           instr
);

  always_comb begin
    instr = data[XLEN-1:0];
    for (int k = 1; k < NUM_INSTR; k++) begin
      if (sel == SEL_W'(k)) instr = data[k*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Small line FIFO between instruction memory and decode; issues one
// instruction per cycle in slot order and supports flush on redirect.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN       = fetch_pkg::XLEN,
  parameter int NUM_INSTR  = fetch_pkg::NUM_INSTR,
  parameter int LINE_DEPTH = 2,
  localparam int CNT_W     = $clog2(NUM_INSTR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_line_valid,
  output logic                      o_line_ready,
  input  logic [NUM_INSTR*XLEN-1:0] i_line_data,
  input  logic [CNT_W:0]            i_line_count,
  input  logic                      i_flush,
  output logic                      o_instr_valid,
  input  logic                      i_instr_ready,
  output logic [XLEN-1:0]           o_instr,
  output logic [CNT_W-1:0]          o_slot,
  output logic                      o_empty
);

  localparam int PTR_W = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam int OCC_W = $clog2(LINE_DEPTH + 1);

  logic [NUM_INSTR*XLEN-1:0] data_mem  [LINE_DEPTH];
  logic [CNT_W:0]            count_mem [LINE_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] slot;

  logic           push;
  logic           store;
  logic           fire;
  logic           last_slot;
  logic           pop;
  logic [CNT_W:0] clamped_count;
  logic [XLEN-1:0] head_instr;

  assign o_line_ready  = rst && (occ != OCC_W'(LINE_DEPTH));
  assign o_instr_valid = (occ != '0);
  assign o_empty       = (occ == '0);
  assign o_slot        = slot;

  assign clamped_count = (CNT_W+1)'(clamp_count(32'(i_line_count), NUM_INSTR));

  // Zero-count lines are handshaken but never occupy an entry.
  assign push  = i_line_valid && o_line_ready;
  assign store = push && !i_flush && (clamped_count != '0);

  assign fire      = o_instr_valid && i_instr_ready;
  assign last_slot = ({1'b0, slot} == (count_mem[rd_ptr] - (CNT_W+1)'(1)));
  assign pop       = fire && last_slot;

  always_ff @(posedge clk) begin
    if (store) begin
      data_mem[wr_ptr]  <= i_line_data;
      count_mem[wr_ptr] <= clamped_count;
    end
  end

  // Reset and flush both drop every buffered line and the slot position.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      slot   <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        slot   <= '0;
      end else if (fire) begin
        slot <= slot + CNT_W'(1);
      end
      occ <= occ + OCC_W'(store) - OCC_W'(pop);
    end
  end

  instr_slot_mux #(
    .XLEN      (XLEN),
    .NUM_INSTR (NUM_INSTR),
    .SEL_W     (CNT_W)
  ) u_slot_mux (
    .data  (data_mem[rd_ptr]),
    .sel   (slot),
    .instr (head_instr)
  );

  assign o_instr = o_instr_valid ? head_instr : '0;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed scenarios plus a
// randomized run, compared against an instruction-queue reference model.
module tb_instr_fetch_buffer;

  localparam int XLEN       = 32;
  localparam int NUM_INSTR  = 5;
  localparam int LINE_DEPTH = 2;
  localparam int CNT_W      = $clog2(NUM_INSTR);
  localparam int LW         = NUM_INSTR * XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_line_valid = 1'b0;
  logic            o_line_ready;
  logic [LW-1:0]   i_line_data = '0;
  logic [CNT_W:0]  i_line_count = '0;
  logic            i_flush = 1'b0;
  logic            o_instr_valid;
  logic            i_instr_ready = 1'b0;
  logic [XLEN-1:0] o_instr;
  logic [CNT_W-1:0] o_slot;
  logic            o_empty;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: every buffered instruction in issue order, plus the
  // length of each buffered line and how far into the head line we are.
  logic [XLEN-1:0] pending[$];
  int              line_len[$];
  int              m_slot = 0;

  instr_fetch_buffer #(
    .XLEN       (XLEN),
    .NUM_INSTR  (NUM_INSTR),
    .LINE_DEPTH (LINE_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_line_valid  (i_line_valid),
    .o_line_ready  (o_line_ready),
    .i_line_data   (i_line_data),
    .i_line_count  (i_line_count),
    .i_flush       (i_flush),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr       (o_instr),
    .o_slot        (o_slot),
    .o_empty       (o_empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare against the model
  // just after, then advance the model as the next rising edge will.
  task automatic applyStimulus(input logic rst_v, input logic lv_v,
                               input logic [LW-1:0] data_v,
                               input logic [CNT_W:0] count_v,
                               input logic flush_v, input logic ready_v);
    logic exp_ready, exp_valid;
    int   n;
    @(negedge clk);
    rst           = rst_v;
    i_line_valid  = lv_v;
    i_line_data   = data_v;
    i_line_count  = count_v;
    i_flush       = flush_v;
    i_instr_ready = ready_v;
    #1;
    exp_ready = rst_v && (line_len.size() < LINE_DEPTH);
    exp_valid = (line_len.size() != 0);
    checkOutput("line_ready", o_line_ready, exp_ready);
    checkOutput("instr_valid", o_instr_valid, exp_valid);
    checkOutput("empty", o_empty, !exp_valid);
    checkOutput("instr", o_instr, exp_valid ? pending[0] : '0);
    checkOutput("slot", o_slot, m_slot);
    if (!rst_v || flush_v) begin
      pending.delete();
      line_len.delete();
      m_slot = 0;
    end else begin
      if (exp_valid && ready_v) begin
        void'(pending.pop_front());
        m_slot++;
        if (m_slot == line_len[0]) begin
          void'(line_len.pop_front());
          m_slot = 0;
        end
      end
      if (lv_v && exp_ready && count_v != 0) begin
        n = (int'(count_v) > NUM_INSTR) ? NUM_INSTR : int'(count_v);
        for (int k = 0; k < n; k++) pending.push_back(data_v[k*XLEN +: XLEN]);
        line_len.push_back(n);
      end
    end
  endtask

  task automatic idle(input logic ready_v);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, ready_v);
  endtask

  logic [LW-1:0] line5, line_a, line_b, line_c, rnd_line;
  int fired;

  initial begin
    line5  = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    line_a = {96'h0, 32'hA1, 32'hA0};
    line_b = {64'h0, 32'hB2, 32'hB1, 32'hB0};
    line_c = {32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};

    // Reset held, then released
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, line5, 4'd5, 1'b0, 1'b1);
      checkOutput("rst_line_ready", o_line_ready, 1'b0);
    end
    checkOutput("rst_empty", o_empty, 1'b1);
    checkOutput("rst_instr", o_instr, 32'h0);
    idle(1'b0);
    checkOutput("release_line_ready", o_line_ready, 1'b1);

    // Single full line streamed out
    applyStimulus(1'b1, 1'b1, line5, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      checkOutput("seq5_instr", o_instr, 32'h11 * (i + 1));
      checkOutput("seq5_slot", o_slot, i);
    end
    idle(1'b1);
    checkOutput("seq5_empty", o_empty, 1'b1);

    // Two short lines back to back, no bubble
    applyStimulus(1'b1, 1'b1, line_a, 4'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, line_b, 4'd3, 1'b0, 1'b1);
    checkOutput("ab_0", o_instr, 32'hA0);
    idle(1'b1); checkOutput("ab_1", o_instr, 32'hA1);
    idle(1'b1); checkOutput("ab_2", o_instr, 32'hB0);
    checkOutput("ab_2_slot", o_slot, 0);
    idle(1'b1); checkOutput("ab_3", o_instr, 32'hB1);
    idle(1'b1); checkOutput("ab_4", o_instr, 32'hB2);
    checkOutput("ab_4_slot", o_slot, 2);
    idle(1'b1);

    // Fill under stall, third line waits for the first head pop
    applyStimulus(1'b1, 1'b1, line_a, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, line_b, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, line_c, 4'd5, 1'b0, 1'b0);
      checkOutput("stall_ready", o_line_ready, 1'b0);
      checkOutput("stall_instr", o_instr, 32'hA0);
    end
    applyStimulus(1'b1, 1'b1, line_c, 4'd5, 1'b0, 1'b1);
    checkOutput("full_a0_ready", o_line_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, line_c, 4'd5, 1'b0, 1'b1);
    checkOutput("full_a1_ready", o_line_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, line_c, 4'd5, 1'b0, 1'b1);
    checkOutput("after_pop_ready", o_line_ready, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    checkOutput("drain_empty", o_empty, 1'b1);

    // Mid-line flush with a line offered in the same cycle
    applyStimulus(1'b1, 1'b1, line5, 4'd5, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b1, 1'b1, line_c, 4'd5, 1'b1, 1'b1);
    idle(1'b1);
    checkOutput("flush_valid", o_instr_valid, 1'b0);
    checkOutput("flush_empty", o_empty, 1'b1);
    idle(1'b1);
    checkOutput("flush_not_stored", o_empty, 1'b1);

    // Zero-count line, then an over-long count clamped to the line size
    applyStimulus(1'b1, 1'b1, line_c, 4'd0, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("zero_count_empty", o_empty, 1'b1);
    applyStimulus(1'b1, 1'b1, line_c, 4'd7, 1'b0, 1'b1);
    fired = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      if (o_instr_valid) fired++;
    end
    checkOutput("clamp_fires", fired, 5);

    // Reset in the middle of a line
    applyStimulus(1'b1, 1'b1, line5, 4'd5, 1'b0, 1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, line_c, 4'd5, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("midreset_empty", o_empty, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NUM_INSTR; k++) rnd_line[k*XLEN +: XLEN] = $urandom;
      applyStimulus($urandom_range(99) != 0, $urandom_range(1) == 1, rnd_line,
                    (CNT_W+1)'($urandom_range(7)), $urandom_range(29) == 0,
                    $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
